// File: rtl/ham_secded_decoder_pipe.sv
// ham_secded_decoder_pipe: two-stage Hamming SEC/SECDED decoder with valid/ready flow control and saturating error counters
module ham_secded_decoder_pipe #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    parameter int SECDED = 1,
    parameter int CNT_W  = 16,
    localparam int N     = DATA_W + PAR_W + SECDED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_single,
    output logic              out_double,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);
    localparam int H = DATA_W + PAR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Bit index of the k-th data bit: the k-th position (1-based) that is not a power of two.
    function automatic int data_pos(input int k);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int p = 1; p <= H; p++)
            if ((p & (p - 1)) != 0) begin
                if (n == k) r = p - 1;
                n++;
            end
        return r;
    endfunction

    logic              advance;
    logic [PAR_W-1:0]  syn;
    logic              op;
    logic              s1_valid;
    logic [N-1:0]      s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_op;
    logic              in_range;
    logic              nz;
    logic              single;
    logic              double;
    logic [N-1:0]      fixed;
    logic [DATA_W-1:0] data;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Syndrome is the XOR of the 1-based positions holding a 1; op covers the whole word.
    always_comb begin
        syn = '0;
        for (int i = 0; i < H; i++) syn = syn ^ (in_code[i] ? PAR_W'(i + 1) : '0);
        op = SECDED != 0 ? ^in_code : 1'b0;
    end

    // Classify the stage-1 word and flip the addressed position when it is correctable.
    always_comb begin
        in_range = int'(s1_syn) <= H;
        nz       = s1_syn != '0;
        single   = SECDED != 0 ? s1_op & in_range : nz & in_range;
        double   = SECDED != 0 ? (s1_op ? ~in_range : nz) : ~in_range;
        fixed    = s1_code;
        for (int i = 0; i < H; i++) fixed[i] = s1_code[i] ^ (single && int'(s1_syn) == i + 1);
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        assign data[k] = fixed[data_pos(k)];
    end

    // Stage 1: capture codeword with its syndrome and overall parity.
    always_ff @(posedge clk)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_op    <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_code  <= in_code;
            s1_syn   <= syn;
            s1_op    <= op;
        end

    // Stage 2: corrected data and flags; flags are masked for bubbles.
    always_ff @(posedge clk)
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_single   <= 1'b0;
            out_double   <= 1'b0;
        end else if (advance) begin
            out_valid    <= s1_valid;
            out_data     <= data;
            out_syndrome <= s1_syn;
            out_single   <= s1_valid & single;
            out_double   <= s1_valid & double;
        end

    // Saturating counters of accepted results; clear beats a simultaneous increment.
    always_ff @(posedge clk)
        if (!rst_n || cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_valid && out_ready) begin
            cnt_corr   <= cnt_corr + CNT_W'(out_single && cnt_corr != CNT_MAX);
            cnt_uncorr <= cnt_uncorr + CNT_W'(out_double && cnt_uncorr != CNT_MAX);
        end
endmodule
